// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup at fetch, update and performance counting at branch resolve in EX.
module branch_target_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 24,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_en,
  input  logic [31:0] PC_IF,
  output logic [31:0] PredictPC,
  output logic        PredictF,
  output logic        PredictPCValid,
  input  logic        br_EX,
  input  logic        stall_EX,
  input  logic [31:0] PC_EX,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        PredictE,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  localparam logic [1:0] CntSnt = 2'b00;
  localparam logic [1:0] CntWnt = 2'b01;
  localparam logic [1:0] CntSt  = 2'b11;

  logic [Entries-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [Entries];
  logic [29:0]         r_target [Entries];
  logic [1:0]          r_cnt    [Entries];
  logic [31:0]         r_br_count;
  logic [31:0]         r_miss_count;

  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0] w_ex_tag;
  logic                w_if_hit;
  logic                w_ex_hit;
  logic                w_upd;
  logic [1:0]          w_ex_cnt;
  logic [1:0]          w_cnt_next;
  logic                w_unused_bits;

  assign w_if_idx = PC_IF[IDX_BITS+1:2];
  assign w_if_tag = PC_IF[31:IDX_BITS+2];
  assign w_ex_idx = PC_EX[IDX_BITS+1:2];
  assign w_ex_tag = PC_EX[31:IDX_BITS+2];

  // Byte-offset bits carry no information for word-aligned instructions.
  assign w_unused_bits = ^{PC_IF[1:0], PC_EX[1:0], br_target[1:0]};

  always_comb begin
    w_if_hit       = bp_en & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    PredictPCValid = w_if_hit;
    PredictF       = w_if_hit & r_cnt[w_if_idx][1];
    PredictPC      = w_if_hit ? {r_target[w_if_idx], 2'b00} : 32'h0;
  end

  assign w_upd      = br_EX & ~stall_EX;
  assign mispredict = w_upd & (br_taken != PredictE);
  // Update-side hit deliberately ignores bp_en so training continues while disabled.
  assign w_ex_hit   = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_cnt   = r_cnt[w_ex_idx];

  always_comb begin
    w_cnt_next = w_ex_cnt;
    if (br_taken) begin
      if (w_ex_cnt != CntSt) w_cnt_next = w_ex_cnt + 2'd1;
    end else begin
      if (w_ex_cnt != CntSnt) w_cnt_next = w_ex_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_br_count   <= '0;
      r_miss_count <= '0;
      for (int i = 0; i < Entries; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CntWnt;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_next;
        if (br_taken) r_target[w_ex_idx] <= br_target[31:2];
      end else if (br_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= br_target[31:2];
        r_cnt[w_ex_idx]    <= CNT_INIT;
      end
      if (r_br_count != 32'hFFFF_FFFF) r_br_count <= r_br_count + 32'd1;
      if (mispredict && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;

endmodule
